bundle_dispatcher: RTL and testbench
====================================

# bundle_dispatcher

Issue controller between bundle fetch and the per-slot functional units. Accepts one VLIW bundle of `NUM_SLOTS` 32-bit instructions via a valid/ready handshake. Pulses `instructionReady` to every issued slot simultaneously, then waits until all issued units have started and finished. Retires the bundle, counts retirements, and flags hung units with a watchdog.

## Interface
- `NUM_SLOTS`, default 4: number of functional units / instruction slots (1..8).
- `TIMEOUT`, default 255: maximum cycles spent in ARM+DRAIN before abort (1..65535).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `bundle_valid` in 1: fetch offers a bundle.
- `bundle_ready` out 1: dispatcher can accept a bundle.
- `bundle` in 32*NUM_SLOTS: slot i = bits [32i+31:32i].
- `bundle_addr` in 64: address of offered bundle.
- `fu_instruction` out 32*NUM_SLOTS: registered slot instructions to units.
- `fu_bundle_addr` out 64: registered bundle address to all units.
- `fu_instruction_ready` out NUM_SLOTS: one-cycle issue pulse per slot.
- `fu_working` in NUM_SLOTS: per-unit `working` flags.
- `busy` out 1: high in any state other than IDLE.
- `bundles_retired` out 32: count of completed bundles.
- `timeout` out 1: sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, ARM, DRAIN.
- `issue_mask` is a NUM_SLOTS-bit register captured at accept (see Configuration).
- IDLE: `bundle_ready`=1. On `bundle_valid`&&`bundle_ready`:
  - latch `bundle` into `fu_instruction`, latch `bundle_addr` into `fu_bundle_addr`, compute `issue_mask`;
  - mask nonzero -> ISSUE;
  - mask zero -> retire immediately (counter +1), stay IDLE.
- ISSUE: `fu_instruction_ready` = `issue_mask` for exactly this cycle -> ARM. Watchdog cleared to 0.
- ARM: wait until (`fu_working` & `issue_mask`) == `issue_mask`, then -> DRAIN. Partial starts are held; no re-issue.
- DRAIN: when (`fu_working` & `issue_mask`) == 0 -> IDLE, `bundles_retired` +1 (wraps 0xFFFF_FFFF -> 0).
- `fu_working` of unmasked slots is ignored in every state.
- Watchdog:
  - 16-bit counter, increments each cycle in ARM or DRAIN.
  - When it equals TIMEOUT in either state, set `timeout`=1 and go to IDLE without incrementing `bundles_retired`.
  - `timeout` clears only on `rst`.
- The units' wait conditions and the watchdog are evaluated at the same edge. If both are true, the state transition wins and no timeout is raised.
- `fu_instruction` and `fu_bundle_addr` hold their value until the next accept.

## Timing
- Reset values: `bundle_ready`=0 during reset, 1 in the first cycle after; all other outputs 0; state IDLE; mask and watchdog 0.
- Reset mid-operation: in-flight bundle is abandoned, `fu_instruction_ready` drops on the reset edge, and the counter and flag clear.
- All outputs are registered except `bundle_ready` and `busy`, which are decoded from state.
- Accept at edge T. ISSUE is cycle T+1, with the pulse visible. Units capture at edge T+2 and raise `working` after it. The earliest ARM->DRAIN transition is edge T+3.
- With 4-stage units (working high 3 cycles), retire occurs at edge T+6 and the next accept at T+7. Sustained throughput is one bundle per 7 cycles.
- No accept is possible in ISSUE, ARM or DRAIN; `bundle_ready`=0 there.
- A zero-mask bundle accepted at T leaves `bundle_ready`=1. A back-to-back accept at T+1 is legal.

## Configuration
- Macro: `DISPATCH_NOP_SKIP_EN`.
- Defined: a slot whose instruction is 32'h0000_0000 (NOP) is cleared in `issue_mask` and never pulsed.
- Not defined: `issue_mask` = all ones. NOP slots are issued like any other instruction, and zero-mask retire never occurs.

## Test plan
- Reset then four ADDUI instructions at addr 0x1000, units modelled with working high 3 cycles -> single 4-bit `fu_instruction_ready`=4'b1111 pulse at T+1, retire at T+6, `bundles_retired`=1, `busy` low at T+7.
- With the macro, bundle {0, ADDUI, 0, 0} -> pulse 4'b0010 only. Without the macro -> pulse 4'b1111.
- With the macro, all-zero bundle on two consecutive cycles -> no pulses, `bundles_retired`=2 after edge T+1, `busy` never high.
- Unit 2 never raises `working`, TIMEOUT=20 -> `timeout`=1 at the 20th ARM/DRAIN cycle, state IDLE, `bundles_retired` unchanged, next bundle accepted normally.
- Unit 0 holds `working` 10 cycles, others 3 cycles -> retire waits for unit 0 (edge T+13).
- Assert `rst` in DRAIN -> next cycle all outputs 0, counter 0; after release, a new bundle completes normally.

Source files
------------

// File: rtl/bundle_dispatcher_if.sv
// Bundle fetch handshake plus per-slot functional-unit lines.
// Master: fetch/unit side. Slave: the dispatcher.
interface bundle_dispatcher_if #(
    parameter int NUM_SLOTS = 4
);
    logic                      bundle_valid;
    logic                      bundle_ready;
    logic [32*NUM_SLOTS-1:0]   bundle;
    logic [63:0]               bundle_addr;
    logic [32*NUM_SLOTS-1:0]   fu_instruction;
    logic [63:0]               fu_bundle_addr;
    logic [NUM_SLOTS-1:0]      fu_instruction_ready;
    logic [NUM_SLOTS-1:0]      fu_working;
    logic                      busy;
    logic [31:0]               bundles_retired;
    logic                      timeout;

    modport master (
        output bundle_valid,
        output bundle,
        output bundle_addr,
        output fu_working,
        input  bundle_ready,
        input  fu_instruction,
        input  fu_bundle_addr,
        input  fu_instruction_ready,
        input  busy,
        input  bundles_retired,
        input  timeout
    );

    modport slave (
        input  bundle_valid,
        input  bundle,
        input  bundle_addr,
        input  fu_working,
        output bundle_ready,
        output fu_instruction,
        output fu_bundle_addr,
        output fu_instruction_ready,
        output busy,
        output bundles_retired,
        output timeout
    );
endinterface

// File: rtl/bundle_dispatcher.sv
// VLIW bundle issue controller with retire counter and watchdog.
// Optional NOP slot skipping via DISPATCH_NOP_SKIP_EN.
module bundle_dispatcher #(
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 255
) (
    input logic                clk,
    input logic                rst,
    bundle_dispatcher_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ARM,
        DRAIN
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    state_t               state;
    state_t               state_next;
    logic [NUM_SLOTS-1:0] mask;
    logic [NUM_SLOTS-1:0] mask_new;
    logic [NUM_SLOTS-1:0] active;
    logic [15:0]          wd;
    logic [15:0]          wd_inc;
    logic                 accept;
    logic                 all_started;
    logic                 all_done;
    logic                 expired;
    logic                 retire;
    logic                 abort;

`ifdef DISPATCH_NOP_SKIP_EN
    always_comb begin
        mask_new = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            mask_new[i] = bus.bundle[32*i +: 32] != 32'h0;
        end
    end
`else
    assign mask_new = '1;
`endif

    // Unmasked slots are ignored by construction here.
    assign active      = bus.fu_working & mask;
    assign all_started = active == mask;
    assign all_done    = active == '0;
    assign wd_inc      = wd + 16'd1;
    assign expired     = wd_inc == WD_LIMIT;

    assign bus.bundle_ready = (state == IDLE) && !rst;
    assign bus.busy         = state != IDLE;
    assign accept           = bus.bundle_valid && bus.bundle_ready;

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (mask_new != '0) begin
                        state_next = ISSUE;
                    end else begin
                        retire = 1'b1;
                    end
                end
            end
            ISSUE: state_next = ARM;
            ARM: begin
                if (all_started) begin
                    state_next = DRAIN;
                end else if (expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            DRAIN: begin
                // Unit completion beats a same-edge watchdog hit.
                if (all_done) begin
                    state_next = IDLE;
                    retire     = 1'b1;
                end else if (expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= IDLE;
            mask                     <= '0;
            wd                       <= '0;
            bus.fu_instruction       <= '0;
            bus.fu_bundle_addr       <= '0;
            bus.fu_instruction_ready <= '0;
            bus.bundles_retired      <= '0;
            bus.timeout              <= 1'b0;
        end else begin
            state                    <= state_next;
            bus.fu_instruction_ready <= '0;
            if (accept) begin
                bus.fu_instruction       <= bus.bundle;
                bus.fu_bundle_addr       <= bus.bundle_addr;
                mask                     <= mask_new;
                bus.fu_instruction_ready <= mask_new;
            end
            if (state == ISSUE) begin
                wd <= '0;
            end else if (state == ARM || state == DRAIN) begin
                wd <= wd_inc;
            end
            if (retire) begin
                bus.bundles_retired <= bus.bundles_retired + 32'd1;
            end
            if (abort) begin
                bus.timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bundle_dispatcher.sv
// Self-checking bench for bundle_dispatcher: vector table, unit model,
// scoreboard of retire latency / count / watchdog flag.
module tb_bundle_dispatcher;
    localparam int NS = 4;
    localparam int TO = 20;
    localparam logic [31:0] ADDUI = 32'h2421_0001;

    logic clk;
    logic rst;

    bundle_dispatcher_if #(.NUM_SLOTS(NS)) bus ();

    bundle_dispatcher #(
        .NUM_SLOTS(NS),
        .TIMEOUT  (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] bundle;
        logic [63:0]  addr;
        logic [31:0]  dur;
        logic [3:0]   mask;
        int           lat;
        bit           to;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] ret;
        bit          to;
    } sb_t;

    vec_t        vecs[8];
    sb_t         sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 0;
    bit          exp_to = 0;

    // Unit model: pulse seen at negedge n=0, working for n in [2, 2+dur).
    logic [31:0] dur = 32'h0;
    int          cnt[NS] = '{-1, -1, -1, -1};

    always @(negedge clk) begin
        logic [NS-1:0] wk;
        wk = '0;
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                cnt[i] = -1;
            end else if (bus.fu_instruction_ready[i]) begin
                cnt[i] = 0;
            end else if (cnt[i] >= 0) begin
                cnt[i] = cnt[i] + 1;
                if (cnt[i] >= 2 + int'(dur[8*i +: 8])) cnt[i] = -1;
            end
            wk[i] = cnt[i] >= 2 && cnt[i] < 2 + int'(dur[8*i +: 8]);
        end
        bus.fu_working = wk;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] model_mask(input logic [127:0] b);
        logic [3:0] nz;
        logic [3:0] m;
        for (int i = 0; i < NS; i++) nz[i] = b[32*i +: 32] != 32'h0;
`ifdef DISPATCH_NOP_SKIP_EN
        m = nz;
`else
        m = 4'hF | nz;
`endif
        return m;
    endfunction

    task automatic add_vec(input int idx, input logic [127:0] b,
                           input logic [63:0] a, input logic [31:0] d);
        int  mx;
        bit  hang;
        vec_t v;
        v.bundle = b;
        v.addr   = a;
        v.dur    = d;
        v.mask   = model_mask(b);
        mx   = 0;
        hang = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (v.mask[i]) begin
                if (d[8*i +: 8] == 8'd0) hang = 1'b1;
                if (int'(d[8*i +: 8]) > mx) mx = int'(d[8*i +: 8]);
            end
        end
        v.to  = hang;
        if (v.mask == 4'h0) v.lat = 0;
        else if (hang) v.lat = TO + 1;
        else v.lat = 3 + mx;
        vecs[idx] = v;
    endtask

    task automatic run_vec(input vec_t v);
        sb_t e;
        int  n;
        @(negedge clk);
        dur              = v.dur;
        bus.bundle_valid = 1'b1;
        bus.bundle       = v.bundle;
        bus.bundle_addr  = v.addr;
        #1;
        chk("ready_idle", 128'(bus.bundle_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        if (v.to) exp_to = 1'b1;
        else exp_ret = exp_ret + 32'd1;
        e = '{lat: v.lat, ret: exp_ret, to: exp_to};
        sbq.push_back(e);
        chk("instr", bus.fu_instruction, v.bundle);
        chk("addr", 128'(bus.fu_bundle_addr), 128'(v.addr));
        chk("pulse", 128'(bus.fu_instruction_ready), 128'(v.mask));
        chk("busy_issue", 128'(bus.busy), 128'(v.mask != 4'h0));
        @(negedge clk);
        bus.bundle_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("pulse_once", 128'(bus.fu_instruction_ready), 128'(0));
        end
        e = sbq.pop_front();
        chk("latency", 128'(n), 128'(e.lat));
        chk("retired", 128'(bus.bundles_retired), 128'(e.ret));
        chk("timeout", 128'(bus.timeout), 128'(e.to));
        chk("instr_hold", bus.fu_instruction, v.bundle);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_instr"}, bus.fu_instruction, 128'(0));
        chk({tag, "_addr"}, 128'(bus.fu_bundle_addr), 128'(0));
        chk({tag, "_pulse"}, 128'(bus.fu_instruction_ready), 128'(0));
        chk({tag, "_busy"}, 128'(bus.busy), 128'(0));
        chk({tag, "_ret"}, 128'(bus.bundles_retired), 128'(0));
        chk({tag, "_to"}, 128'(bus.timeout), 128'(0));
        chk({tag, "_ready"}, 128'(bus.bundle_ready), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst              = 1'b1;
        bus.bundle_valid = 1'b0;
        bus.bundle       = '0;
        bus.bundle_addr  = '0;
        bus.fu_working   = '0;

        add_vec(0, {ADDUI, ADDUI + 32'd1, ADDUI + 32'd2, ADDUI + 32'd3},
                64'h1000, 32'h0303_0303);
        add_vec(1, {32'h0, 32'h0, ADDUI, 32'h0}, 64'h1010, 32'h0303_0303);
        add_vec(2, 128'h0, 64'h2000, 32'h0303_0303);
        add_vec(3, {4{ADDUI}}, 64'h3000, 32'h0303_030A);
        add_vec(4, {32'h1, 32'h2, 32'h3, 32'h4}, 64'hFFFF_0000_0000_1234,
                32'h0104_0502);
        add_vec(5, {4{32'hDEAD_BEEF}}, 64'h4000, 32'h0300_0303);
        add_vec(6, {32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003, 32'h3C3C_0004},
                64'h5000, 32'h0303_0303);
        add_vec(7, {4{ADDUI}}, 64'h6000, 32'h0101_0101);

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 128'(bus.bundle_ready), 128'(1'b1));
        chk("busy_after_reset", 128'(bus.busy), 128'(1'b0));

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

`ifdef DISPATCH_NOP_SKIP_EN
        @(negedge clk);
        bus.bundle_valid = 1'b1;
        bus.bundle       = '0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            exp_ret = exp_ret + 32'd1;
            chk("zero_ret", 128'(bus.bundles_retired), 128'(exp_ret));
            chk("zero_busy", 128'(bus.busy), 128'(0));
            chk("zero_pulse", 128'(bus.fu_instruction_ready), 128'(0));
            chk("zero_ready", 128'(bus.bundle_ready), 128'(1'b1));
        end
        @(negedge clk);
        bus.bundle_valid = 1'b0;
`endif

        // Reset while the bundle is draining.
        @(negedge clk);
        dur              = 32'h0303_0303;
        bus.bundle_valid = 1'b1;
        bus.bundle       = {4{ADDUI}};
        bus.bundle_addr  = 64'h7000;
        @(posedge clk);
        @(negedge clk);
        bus.bundle_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_drain", 128'(bus.busy), 128'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst     = 1'b0;
        exp_ret = 0;
        exp_to  = 1'b0;
        #1;
        chk("ready_release", 128'(bus.bundle_ready), 128'(1'b1));
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
